// File: rtl/ysyx_22040237_mdu.sv
// Multi-cycle M-extension sequencer: shift-add multiply and restoring divide,
// one bit per cycle on a shared accumulator / operand / shifter datapath.
module ysyx_22040237_mdu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [4:0]      req_rd_idx_i,
  input  logic [XLEN-1:0] req_op1_i,
  input  logic [XLEN-1:0] req_op2_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [4:0]      resp_rd_idx_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state_q, state_d;

  logic [XLEN-1:0]  acc_q;   // product accumulator / partial remainder
  logic [XLEN-1:0]  opb_q;   // multiplicand / divisor magnitude
  logic [XLEN-1:0]  opc_q;   // multiplier / dividend shifting into quotient
  logic [2:0]       op_q;
  logic             qneg_q, rneg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  res_q;
  logic [4:0]       rd_q;

  // request decode
  logic            accept, is_mul, is_divop, is_signed, is_rem, legal;
  logic            div_zero, ovf, special, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    accept    = req_valid_i && req_ready_o && !flush_i;
    is_mul    = (req_op_i == 3'b000);
    is_divop  = req_op_i[2];
    is_signed = req_op_i[2] & ~req_op_i[0];
    is_rem    = req_op_i[1];
    legal     = is_mul | is_divop;
    div_zero  = is_divop && (req_op2_i == '0);
    ovf       = is_signed && (req_op1_i == INT_MIN) && (req_op2_i == '1);
    special   = !legal || div_zero || ovf;
    a_neg     = is_signed & req_op1_i[XLEN-1];
    b_neg     = is_signed & req_op2_i[XLEN-1];
    a_mag     = a_neg ? -req_op1_i : req_op1_i;
    b_mag     = b_neg ? -req_op2_i : req_op2_i;
    special_res = '0;
    if (div_zero)  special_res = is_rem ? req_op1_i : '1;
    else if (ovf)  special_res = is_rem ? '0 : req_op1_i;
  end

  // one iteration of each algorithm
  logic [XLEN-1:0] mul_acc_nxt, div_acc_nxt, div_c_nxt;
  logic [XLEN:0]   trial;
  logic            last;

  always_comb begin
    mul_acc_nxt = acc_q + (opc_q[0] ? opb_q : '0);
    trial       = {acc_q, opc_q[XLEN-1]} - {1'b0, opb_q};
    if (!trial[XLEN]) begin
      div_acc_nxt = trial[XLEN-1:0];
      div_c_nxt   = {opc_q[XLEN-2:0], 1'b1};
    end else begin
      div_acc_nxt = {acc_q[XLEN-2:0], opc_q[XLEN-1]};
      div_c_nxt   = {opc_q[XLEN-2:0], 1'b0};
    end
    last = (cnt_q == CNT_W'(XLEN-1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: if (last) state_d = S_DONE;
      S_DONE: if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_comb begin
    req_ready_o   = (state_q == S_IDLE);
    resp_valid_o  = (state_q == S_DONE);
    busy_o        = (state_q != S_IDLE);
    resp_data_o   = res_q;
    resp_rd_idx_o = rd_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      opb_q  <= '0;
      opc_q  <= '0;
      op_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      op_q   <= req_op_i;
      rd_q   <= req_rd_idx_i;
      cnt_q  <= '0;
      acc_q  <= '0;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      opb_q  <= is_mul ? req_op1_i : b_mag;
      opc_q  <= is_mul ? req_op2_i : a_mag;
      if (special) res_q <= special_res;
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q + 1'b1;
      if (op_q == 3'b000) begin
        acc_q <= mul_acc_nxt;
        opb_q <= opb_q << 1;
        opc_q <= opc_q >> 1;
        if (last) res_q <= mul_acc_nxt;
      end else begin
        acc_q <= div_acc_nxt;
        opc_q <= div_c_nxt;
        if (last) begin
          if (op_q[1]) res_q <= rneg_q ? -div_acc_nxt : div_acc_nxt;
          else         res_q <= qneg_q ? -div_c_nxt : div_c_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_mdu.sv
// Bench for ysyx_22040237_mdu: directed literal cases plus random ops checked
// against a plain-arithmetic reference for result and latency.
module tb_ysyx_22040237_mdu;
  localparam int XLEN = 64;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 0, rst_n = 0, flush_i = 0;
  logic            req_valid_i = 0, req_ready_o, resp_valid_o, resp_ready_i = 0, busy_o;
  logic [2:0]      req_op_i = 0;
  logic [4:0]      req_rd_idx_i = 0, resp_rd_idx_o;
  logic [XLEN-1:0] req_op1_i = 0, req_op2_i = 0, resp_data_o;

  int total = 0, bad = 0;

  ysyx_22040237_mdu #(.XLEN(64), .CNT_W(6)) dut (
    .clk(clk), .rst(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_rd_idx_i(req_rd_idx_i), .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rd_idx_o(resp_rd_idx_o), .resp_data_o(resp_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic ov;
    ov = (a == MIN) && (b == ONES);
    case (op)
      3'b000: return a * b;
      3'b100: return (b == 0) ? ONES : ov ? a : 64'($signed(a) / $signed(b));
      3'b101: return (b == 0) ? ONES : a / b;
      3'b110: return (b == 0) ? a : ov ? 64'd0 : 64'($signed(a) % $signed(b));
      3'b111: return (b == 0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op != 3'b000 && !op[2]) return 1;
    if (op[2] && b == 0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == MIN && b == ONES) return 1;
    return 65;
  endfunction

  // Starts and ends on a negedge; issues one op, checks latency, result and handshake.
  task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] exp, input int exp_lat, input int hold);
    int cyc;
    chk("ready_before_req", {63'd0, req_ready_o}, 64'd1);
    req_valid_i = 1; req_op_i = op; req_op1_i = a; req_op2_i = b; req_rd_idx_i = rd;
    @(posedge clk); #1;
    req_valid_i = 0; req_op1_i = $urandom; req_op2_i = $urandom; req_rd_idx_i = 5'($urandom);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
        chk("busy_inflight", {62'd0, busy_o, req_ready_o}, 64'd2);
        break;
      end
      if (resp_valid_o) break;
      if (cyc > 200) begin
        chk("resp_timeout", 64'(cyc), 64'(exp_lat));
        return;
      end
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("resp_data", resp_data_o, exp);
    chk("resp_rd", 64'(resp_rd_idx_o), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_state", {61'd0, resp_valid_o, req_ready_o, busy_o}, 64'd5);
      chk("hold_data", resp_data_o, exp);
      chk("hold_rd", 64'(resp_rd_idx_o), 64'(rd));
    end
    resp_ready_i = 1;
    @(posedge clk); #1;
    resp_ready_i = 0;
    @(negedge clk);
    chk("post_handshake", {61'd0, resp_valid_o, req_ready_o, busy_o}, 64'd2);
  endtask

  task automatic rnd_op();
    logic [2:0] op;
    logic [63:0] a, b;
    int k;
    k = $urandom_range(0, 6);
    op = (k == 6) ? 3'b011 : (k == 5) ? 3'b000 : {1'b1, 2'($urandom)};
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: b = 64'($urandom_range(0, 15));
      1: b = 0;
      2: begin a = MIN; b = ONES; end
      3: begin a = 64'($urandom); b = 64'($urandom_range(1, 1000)); end
      4: b = -64'($urandom_range(1, 1000));
      default: ;
    endcase
    do_op(op, a, b, 5'($urandom), ref_res(op, a, b), ref_lat(op, a, b), $urandom_range(0, 3));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", {61'd0, req_ready_o, resp_valid_o, busy_o}, 64'd4);
    chk("rst_data", resp_data_o, 64'd0);
    chk("rst_rd", 64'(resp_rd_idx_o), 64'd0);
    rst_n = 1;
    @(negedge clk);

    do_op(3'b000, 64'd7, -64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    do_op(3'b100, -64'd7, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    do_op(3'b110, -64'd7, 64'd2, 5'd2, ONES, 65, 0);
    do_op(3'b101, 64'd100, 64'd7, 5'd3, 64'd14, 65, 0);
    do_op(3'b111, 64'd100, 64'd7, 5'd4, 64'd2, 65, 0);
    do_op(3'b101, 64'd123, 64'd0, 5'd6, ONES, 1, 0);
    do_op(3'b110, MIN, ONES, 5'd7, 64'd0, 1, 0);
    do_op(3'b100, MIN, ONES, 5'd8, MIN, 1, 0);
    do_op(3'b110, 64'd5, 64'd0, 5'd9, 64'd5, 1, 0);
    do_op(3'b010, 64'd5, 64'd3, 5'd10, 64'd0, 1, 0);
    do_op(3'b000, 64'd12345, 64'd1000, 5'd31, 64'd12345000, 65, 10);

    // flush mid-CALC beats a simultaneous request
    req_valid_i = 1; req_op_i = 3'b000; req_op1_i = 64'd3; req_op2_i = 64'd4; req_rd_idx_i = 5'd11;
    @(posedge clk); #1;
    req_valid_i = 0;
    repeat (30) @(negedge clk);
    flush_i = 1; req_valid_i = 1; req_op_i = 3'b101; req_op1_i = 64'd9; req_op2_i = 64'd0;
    @(posedge clk); #1;
    flush_i = 0; req_valid_i = 0;
    @(negedge clk);
    chk("after_flush", {61'd0, resp_valid_o, req_ready_o, busy_o}, 64'd2);
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_accept", {61'd0, resp_valid_o, req_ready_o, busy_o}, 64'd2);
    end
    do_op(3'b000, 64'd6, 64'd7, 5'd12, 64'd42, 65, 0);

    // asynchronous reset mid-CALC
    req_valid_i = 1; req_op_i = 3'b100; req_op1_i = 64'd1000; req_op2_i = 64'd3; req_rd_idx_i = 5'd13;
    @(posedge clk); #1;
    req_valid_i = 0;
    repeat (20) @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_rst_outputs", {61'd0, req_ready_o, resp_valid_o, busy_o}, 64'd4);
    chk("async_rst_data", resp_data_o, 64'd0);
    chk("async_rst_rd", 64'(resp_rd_idx_o), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_op(3'b100, 64'd1000, 64'd3, 5'd14, 64'd333, 65, 0);

    for (int n = 0; n < 40; n++) rnd_op();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL global_timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
